// File: rtl/game_state_fsm.sv
// ============================================================================
// Module      : game_state_fsm
// Description : Game-flow controller for N players. Walks through a start
//               menu, a timed initialisation phase and a sample/move run
//               loop with pause. Each player has a clamped 12-bit X/Y
//               position. Also produces the game tick and a one-cycle update
//               strobe for the render/sprite path.
// Config      : `define ROUND_TIMER_EN adds a round timer that ends the game
//               (state OVER) after ROUND_TICKS run ticks. Without it, OVER
//               cannot be reached and game_over is tied low.
// Ports       : clock     - system clock
//               reset     - synchronous, active-high reset
//               controls  - player i control field at [i*CTRL_W +: CTRL_W]
//                           bit0 up, bit1 down, bit2 left, bit3 right,
//                           bit4 start
//               tick      - one-cycle pulse every TICK_DIV cycles
//               update    - one-cycle strobe when moves are applied
//               state     - current FSM state code
//               pos_x     - player i X at [i*12 +: 12]
//               pos_y     - player i Y at [i*12 +: 12]
//               game_over - high while in state OVER
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_state_fsm #(
  parameter int NUM_PLAYERS = 2,
  parameter int CTRL_W      = 9,
  parameter int TICK_DIV    = 2701000,
  parameter int INIT_TICKS  = 12,
  parameter int STEP        = 4,
  parameter int X_MAX       = 1279,
  parameter int Y_MAX       = 1023,
  parameter int ROUND_TICKS = 2400
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PLAYERS*CTRL_W-1:0] controls,
  output logic                          tick,
  output logic                          update,
  output logic [2:0]                    state,
  output logic [NUM_PLAYERS*12-1:0]     pos_x,
  output logic [NUM_PLAYERS*12-1:0]     pos_y,
  output logic                          game_over
);

  localparam logic [2:0] c_st_menu   = 3'd0;
  localparam logic [2:0] c_st_init   = 3'd1;
  localparam logic [2:0] c_st_pause  = 3'd2;
  localparam logic [2:0] c_st_sample = 3'd3;
  localparam logic [2:0] c_st_move   = 3'd4;
  localparam logic [2:0] c_st_over   = 3'd5;

  localparam int c_cnt_w  = $clog2(TICK_DIV);
  localparam int c_init_w = $clog2(INIT_TICKS + 1);

  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_TICKS);

  // Movement arithmetic is done in 13 bits so that neither the decrement
  // below zero nor the increment past the limit can wrap.
  localparam logic [12:0] c_step  = 13'(STEP);
  localparam logic [12:0] c_x_max = 13'(X_MAX);
  localparam logic [12:0] c_y_max = 13'(Y_MAX);

  function automatic logic [NUM_PLAYERS*12-1:0] spawn_x_vec();
    logic [NUM_PLAYERS*12-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      v[i*12 +: 12] = 12'((i + 1) * X_MAX / (NUM_PLAYERS + 1));
    end
    return v;
  endfunction

  localparam logic [NUM_PLAYERS*12-1:0] c_spawn_x = spawn_x_vec();
  localparam logic [NUM_PLAYERS*12-1:0] c_spawn_y = {NUM_PLAYERS{12'(Y_MAX / 2)}};

  // One axis of motion: opposing requests cancel, otherwise step and clamp.
  function automatic logic [11:0] step_axis(input logic [11:0] p,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [12:0] lim);
    logic [12:0] w;
    logic [11:0] r;
    w = {1'b0, p};
    r = p;
    if (dec && !inc) begin
      r = (w < c_step) ? 12'd0 : 12'(w - c_step);
    end else if (inc && !dec) begin
      r = (w > lim - c_step) ? lim[11:0] : 12'(w + c_step);
    end
    return r;
  endfunction

  logic [2:0]                state_q, state_d;
  logic [c_cnt_w-1:0]        cnt_q, cnt_d;
  logic                      tick_q, tick_d;
  logic                      update_q, update_d;
  logic                      start_prev_q, start_prev_d;
  logic [c_init_w-1:0]       init_q, init_d;
  logic [NUM_PLAYERS*4-1:0]  buf_q, buf_d;
  logic [NUM_PLAYERS*12-1:0] pos_x_q, pos_x_d;
  logic [NUM_PLAYERS*12-1:0] pos_y_q, pos_y_d;

  logic [NUM_PLAYERS-1:0]    w_start_bits;
  logic                      w_start_any;
  logic                      w_start_edge;
  logic                      w_init_done;
  logic                      w_round_end;
  logic                      w_unused_ctrl;

  generate
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      assign w_start_bits[g] = controls[g*CTRL_W + 4];
    end
  endgenerate

  assign w_start_any   = |w_start_bits;
  assign w_start_edge  = w_start_any & ~start_prev_q;
  assign w_init_done   = tick_q && ((init_q + c_init_w'(1)) == c_init_last);
  // Control bits above start carry no meaning for this block.
  assign w_unused_ctrl = ^controls;

`ifdef ROUND_TIMER_EN
  localparam int c_round_w = $clog2(ROUND_TICKS + 1);
  localparam logic [c_round_w-1:0] c_round_last = c_round_w'(ROUND_TICKS);

  logic [c_round_w-1:0] round_q, round_d;
  logic                 w_round_run;

  // Round time only advances while the game is actually running.
  assign w_round_run = tick_q && ((state_q == c_st_sample) || (state_q == c_st_move));
  assign w_round_end = w_round_run && ((round_q + c_round_w'(1)) == c_round_last);
  assign game_over   = (state_q == c_st_over);

  always_comb begin
    round_d = round_q;
    if ((state_q == c_st_init) && w_init_done) begin
      round_d = '0;
    end else if (w_round_run) begin
      round_d = round_q + c_round_w'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end
`else
  logic w_unused_round;

  assign w_round_end    = 1'b0;
  assign game_over      = 1'b0;
  assign w_unused_round = (ROUND_TICKS > 0);
`endif

  always_comb begin
    state_d      = state_q;
    update_d     = 1'b0;
    start_prev_d = w_start_any;
    init_d       = init_q;
    buf_d        = buf_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;

    // Free-running divider; tick_q is high the cycle after the terminal count.
    tick_d = (cnt_q == c_cnt_last);
    cnt_d  = tick_d ? '0 : cnt_q + c_cnt_w'(1);

    case (state_q)
      c_st_menu: begin
        if (w_start_edge) begin
          pos_x_d = c_spawn_x;
          pos_y_d = c_spawn_y;
          init_d  = '0;
          state_d = c_st_init;
        end
      end
      c_st_init: begin
        if (tick_q) begin
          init_d = init_q + c_init_w'(1);
          if (w_init_done) begin
            state_d = c_st_sample;
          end
        end
      end
      c_st_sample: begin
        if (w_round_end) begin
          state_d = c_st_over;
        end else if (w_start_edge) begin
          state_d = c_st_pause;
        end else begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            buf_d[i*4 +: 4] = controls[i*CTRL_W +: 4];
          end
          state_d = c_st_move;
        end
      end
      c_st_move: begin
        // Round end beats pause, and pause beats a coincident move tick.
        if (w_round_end) begin
          state_d = c_st_over;
        end else if (w_start_edge) begin
          state_d = c_st_pause;
        end else if (tick_q) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            pos_x_d[i*12 +: 12] = step_axis(pos_x_q[i*12 +: 12], buf_q[i*4 + 2],
                                            buf_q[i*4 + 3], c_x_max);
            pos_y_d[i*12 +: 12] = step_axis(pos_y_q[i*12 +: 12], buf_q[i*4 + 0],
                                            buf_q[i*4 + 1], c_y_max);
          end
          update_d = 1'b1;
          state_d  = c_st_sample;
        end
      end
      c_st_pause: begin
        if (w_start_edge) begin
          state_d = c_st_sample;
        end
      end
      c_st_over: begin
`ifdef ROUND_TIMER_EN
        if (w_start_edge) begin
          state_d = c_st_menu;
        end
`else
        state_d = c_st_menu;
`endif
      end
      default: begin
        state_d = c_st_menu;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= c_st_menu;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      update_q     <= 1'b0;
      start_prev_q <= 1'b0;
      init_q       <= '0;
      buf_q        <= '0;
      pos_x_q      <= c_spawn_x;
      pos_y_q      <= c_spawn_y;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      update_q     <= update_d;
      start_prev_q <= start_prev_d;
      init_q       <= init_d;
      buf_q        <= buf_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
    end
  end

  assign tick   = tick_q;
  assign update = update_q;
  assign state  = state_q;
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_fsm.sv
// ============================================================================
// Module      : tb_game_state_fsm
// Description : Self-checking bench for game_state_fsm. A cycle-level model
//               of the game rules (integer positions, min/max clamping)
//               runs next to the design. Directed steps cover the tick
//               period, the start sequence, clamping, opposing inputs, pause
//               priority and reset with start held, followed by a randomized
//               run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_state_fsm;

  localparam int NP = 2;
  localparam int CW = 9;
  localparam int TD = 4;
  localparam int IT = 3;
  localparam int ST = 4;
  localparam int XM = 1279;
  localparam int YM = 1023;
  localparam int RT = 400;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NP*CW-1:0]  controls = '0;
  logic              tick;
  logic              update;
  logic [2:0]        state;
  logic [NP*12-1:0]  pos_x;
  logic [NP*12-1:0]  pos_y;
  logic              game_over;

  always #5 clock = ~clock;

  game_state_fsm #(
    .NUM_PLAYERS(NP), .CTRL_W(CW), .TICK_DIV(TD), .INIT_TICKS(IT),
    .STEP(ST), .X_MAX(XM), .Y_MAX(YM), .ROUND_TICKS(RT)
  ) dut (
    .clock(clock), .reset(reset), .controls(controls), .tick(tick),
    .update(update), .state(state), .pos_x(pos_x), .pos_y(pos_y),
    .game_over(game_over)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: 0 menu, 1 init, 2 pause, 3 sample, 4 move, 5 over
  int       m_state, m_cnt, m_tick, m_upd, m_init, m_prev, m_round;
  logic [3:0] m_buf [NP];
  int       m_x [NP];
  int       m_y [NP];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int mv(input int p, input bit dec, input bit inc, input int lim);
    if (dec && !inc) return (p - ST < 0) ? 0 : p - ST;
    if (inc && !dec) return (p + ST > lim) ? lim : p + ST;
    return p;
  endfunction

  task automatic spawn();
    for (int i = 0; i < NP; i++) begin
      m_x[i] = (i + 1) * XM / (NP + 1);
      m_y[i] = YM / 2;
    end
  endtask

  task automatic model_step(input logic rst, input logic [NP*CW-1:0] ctl);
    bit sa, se, old_tick, rend;
    int n_upd;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_tick = 0; m_upd = 0; m_init = 0;
      m_prev = 0; m_round = 0;
      for (int i = 0; i < NP; i++) m_buf[i] = 4'd0;
      spawn();
    end else begin
      sa = 1'b0;
      for (int i = 0; i < NP; i++) sa = sa | ctl[i*CW + 4];
      se       = sa && (m_prev == 0);
      old_tick = (m_tick == 1);
      m_tick   = (m_cnt == TD - 1) ? 1 : 0;
      m_cnt    = (m_cnt + 1) % TD;
      n_upd    = 0;
      rend     = 1'b0;
`ifdef ROUND_TIMER_EN
      if (old_tick && (m_state == 3 || m_state == 4)) begin
        m_round++;
        rend = (m_round == RT);
      end
`endif
      case (m_state)
        0: if (se) begin spawn(); m_init = 0; m_state = 1; end
        1: if (old_tick) begin
             m_init++;
             if (m_init == IT) begin m_state = 3; m_round = 0; end
           end
        3: if (rend) m_state = 5;
           else if (se) m_state = 2;
           else begin
             for (int i = 0; i < NP; i++) m_buf[i] = ctl[i*CW +: 4];
             m_state = 4;
           end
        4: if (rend) m_state = 5;
           else if (se) m_state = 2;
           else if (old_tick) begin
             for (int i = 0; i < NP; i++) begin
               m_x[i] = mv(m_x[i], m_buf[i][2], m_buf[i][3], XM);
               m_y[i] = mv(m_y[i], m_buf[i][0], m_buf[i][1], YM);
             end
             n_upd = 1;
             m_state = 3;
           end
        2: if (se) m_state = 3;
        5: if (se) m_state = 0;
        default: m_state = 0;
      endcase
      m_upd  = n_upd;
      m_prev = sa ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    chk("tick", tick, m_tick);
    chk("update", update, m_upd);
    chk("state", state, m_state);
    chk("game_over", game_over, (m_state == 5) ? 1 : 0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("pos_x%0d", i), pos_x[i*12 +: 12], m_x[i]);
      chk($sformatf("pos_y%0d", i), pos_y[i*12 +: 12], m_y[i]);
    end
  endtask

  task automatic cyc(input logic rst, input logic [NP*CW-1:0] ctl);
    reset    = rst;
    controls = ctl;
    model_step(rst, ctl);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  function automatic logic [NP*CW-1:0] rnd_ctl(input int start_odds);
    logic [NP*CW-1:0] v;
    v = NP*CW'($urandom);
    v[4] = 1'b0;
    v[CW + 4] = 1'b0;
    if (start_odds > 0 && $urandom_range(0, start_odds - 1) == 0) v[4] = 1'b1;
    if (start_odds > 0 && $urandom_range(0, start_odds - 1) == 0) v[CW + 4] = 1'b1;
    return v;
  endfunction

  localparam logic [NP*CW-1:0] C_IDLE    = '0;
  localparam logic [NP*CW-1:0] C_P0_ST   = 18'h00010;
  localparam logic [NP*CW-1:0] C_P1_ST   = 18'h02000;
  localparam logic [NP*CW-1:0] C_P0_LEFT = 18'h00004;
  localparam logic [NP*CW-1:0] C_P0_LRD  = 18'h0000E;

  initial begin
    int sx[NP];
    int sy[NP];
    int ucnt;

    // Reset and tick period
    for (int k = 0; k < 3; k++) cyc(1'b1, C_IDLE);
    chk("reset_state", state, 0);
    chk("reset_tick", tick, 0);
    chk("reset_update", update, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, C_IDLE);
      chk($sformatf("tick_period_c%0d", k), tick, (k % 4 == 0) ? 1 : 0);
    end

    // Start sequence
    cyc(1'b0, C_P1_ST);
    chk("start_to_init", state, 1);
    for (int k = 0; k < 40 && state != 3; k++) cyc(1'b0, C_IDLE);
    chk("init_reached_sample", state, 3);
    chk("spawn_x0", pos_x[11:0], 426);
    chk("spawn_y0", pos_y[11:0], 511);
    chk("spawn_x1", pos_x[23:12], 852);
    chk("spawn_y1", pos_y[23:12], 511);
    cyc(1'b0, C_IDLE);
    chk("sample_to_move", state, 4);

    // Hold left until P0 clamps at x=0, then updates keep pulsing
    for (int k = 0; k < 130 * TD; k++) cyc(1'b0, C_P0_LEFT);
    chk("clamp_x0_zero", pos_x[11:0], 0);
    ucnt = 0;
    for (int k = 0; k < 4 * TD; k++) begin
      cyc(1'b0, C_P0_LEFT);
      if (update) ucnt++;
    end
    chk("clamp_update_count", ucnt, 4);
    chk("clamp_x0_stays", pos_x[11:0], 0);

    // Opposing inputs: left+right cancel, down applies; P1 idle
    for (int k = 0; k < 8; k++) cyc(1'b0, C_P0_LRD);
    for (int i = 0; i < NP; i++) begin sx[i] = m_x[i]; sy[i] = m_y[i]; end
    ucnt = 0;
    for (int k = 0; k < 5 * TD; k++) begin
      cyc(1'b0, C_P0_LRD);
      if (update) ucnt++;
    end
    chk("conflict_updates", ucnt, 5);
    chk("conflict_x0", pos_x[11:0], sx[0]);
    chk("conflict_y0", pos_y[11:0], sy[0] + ST * 5);
    chk("conflict_x1", pos_x[23:12], sx[1]);
    chk("conflict_y1", pos_y[23:12], sy[1]);

    // Pause on a start edge coinciding with a MOVE tick
    for (int k = 0; k < 20 && !(m_tick == 1 && m_state == 4); k++) cyc(1'b0, C_P0_LRD);
    cyc(1'b0, C_P0_LRD | C_P0_ST);
    chk("pause_on_tick_state", state, 2);
    chk("pause_on_tick_update", update, 0);
    for (int i = 0; i < NP; i++) begin sx[i] = m_x[i]; sy[i] = m_y[i]; end
    ucnt = 0;
    for (int k = 0; k < 5 * TD; k++) begin
      cyc(1'b0, C_P0_LRD);
      if (update) ucnt++;
    end
    chk("pause_no_updates", ucnt, 0);
    chk("pause_frozen_x0", pos_x[11:0], sx[0]);
    chk("pause_frozen_y0", pos_y[11:0], sy[0]);
    chk("pause_frozen_x1", pos_x[23:12], sx[1]);
    cyc(1'b0, C_P0_LRD | C_P0_ST);
    chk("resume_to_sample", state, 3);

    // Reset mid-game with start held through release
    cyc(1'b1, C_IDLE);
    chk("rerst_state", state, 0);
    chk("rerst_x0", pos_x[11:0], 426);
    chk("rerst_x1", pos_x[23:12], 852);
    cyc(1'b1, C_P0_ST);
    cyc(1'b0, C_P0_ST);
    chk("start_held_through_reset", state, 1);

    // Randomized run with occasional start presses
    for (int k = 0; k < 600; k++) cyc(1'b0, rnd_ctl(40));

`ifdef ROUND_TIMER_EN
    // Keep the game running until the round timer ends it
    for (int k = 0; k < 4000 && state != 5; k++) begin
      logic [NP*CW-1:0] v;
      v = rnd_ctl(0);
      if ((m_state == 0 || m_state == 2) && m_prev == 0) v[4] = 1'b1;
      cyc(1'b0, v);
    end
    chk("round_over_state", state, 5);
    chk("round_game_over", game_over, 1);
    for (int k = 0; k < 8; k++) cyc(1'b0, rnd_ctl(0));
    cyc(1'b0, C_P0_ST);
    chk("over_to_menu", state, 0);
    chk("over_cleared", game_over, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
